// File: rtl/display_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Width needed to count up to the longer of the lit and dead-time phases.
    function automatic int cnt_width(input int scan_div, input int blank_cycles);
        int m;
        m = (scan_div > blank_cycles) ? scan_div : blank_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lz_mask.sv
// Leading-zero suppress mask: digit i (i>=1) is blanked when it and every
// more significant nibble are zero. Digit 0 always shows.
module lz_mask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] disp,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   suppress
);

    logic run;

    always_comb begin
        suppress = '0;
        run      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run         = run & (disp[4*i +: 4] == 4'h0);
            suppress[i] = lz_en & run;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller sharing one BCD-to-7-seg decoder across NUM_DIGITS digits,
// with double-buffered value, dead-time between digits and zero blanking.
module display_scan_ctrl
    import display_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CW = cnt_width(SCAN_DIV, BLANK_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    // With no dead-time every digit boundary goes straight to the next SHOW.
    localparam state_t ENTRY = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    state_t                  state, state_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_nx;
    logic [4*NUM_DIGITS-1:0] disp, disp_nx;
    logic                    pending_nx;
    logic                    commit;
    logic                    fd_nx;
    logic [NUM_DIGITS-1:0]   an_nx;
    logic [3:0]              bcd_nx;
    logic [NUM_DIGITS-1:0]   suppress;

    // Outputs are registered from next-state values, so the mask must see
    // the value that will be on display after this edge.
    lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
        .disp     (disp_nx),
        .lz_en    (lz_en),
        .suppress (suppress)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        commit   = 1'b0;
        fd_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = ENTRY;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                    commit   = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_nx = SHOW;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end else if (cnt == SHOW_LAST) begin
                    state_nx = ENTRY;
                    cnt_nx   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nx = '0;
                        fd_nx  = 1'b1;
                        commit = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
                cnt_nx   = '0;
            end
        endcase

        // Commit before load so a load on the frame edge re-arms pending.
        disp_nx    = disp;
        shadow_nx  = shadow;
        pending_nx = pending;
        if (commit && pending) begin
            disp_nx    = shadow;
            pending_nx = 1'b0;
        end
        if (load) begin
            shadow_nx  = value_in;
            pending_nx = 1'b1;
        end

        an_nx  = '1;
        bcd_nx = BLANK_CODE;
        if (state_nx == SHOW) begin
            an_nx[idx_nx] = 1'b0;
            bcd_nx = suppress[idx_nx] ? BLANK_CODE : disp_nx[{idx_nx, 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            bcd_out    <= BLANK_CODE;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            shadow     <= shadow_nx;
            disp       <= disp_nx;
            pending    <= pending_nx;
            bcd_out    <= bcd_nx;
            an_n       <= an_nx;
            frame_done <= fd_nx;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with 4 digits, 4-cycle scan, 1-cycle dead-time.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] value_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic        frame_done;
    logic        pending;

    int checks = 0;
    int errors = 0;

    display_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value_in   (value_in),
        .load       (load),
        .lz_en      (lz_en),
        .bcd_out    (bcd_out),
        .an_n       (an_n),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_blank(input string tag);
        logic [3:0] all_off;
        logic [3:0] blank_code;
        all_off    = 4'b1111;
        blank_code = 4'hF;
        check({tag, "_an"}, {12'h0, an_n}, {12'h0, all_off});
        check({tag, "_bcd"}, {12'h0, bcd_out}, {12'h0, blank_code});
    endtask

    // Walks one full frame starting at the cycle after the dead-time edge of
    // digit 0. exp nibble d is the expected code for digit d. Optional loads
    // are driven at frame cycle indexes la / lb (-1 = none).
    task automatic run_frame(input string tag, input logic [15:0] exp,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb);
        int c;
        logic [3:0] an_exp;
        logic [3:0] code_exp;
        c = 0;
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 5; k++) begin
                if (k == 0) begin
                    check_blank({tag, "_gap"});
                end else begin
                    an_exp   = 4'b1111;
                    an_exp[d] = 1'b0;
                    code_exp = exp[4*d +: 4];
                    check({tag, "_an"}, {12'h0, an_n}, {12'h0, an_exp});
                    check({tag, "_bcd"}, {12'h0, bcd_out}, {12'h0, code_exp});
                    check({tag, "_fd_low"}, {15'h0, frame_done}, 16'h0);
                end
                if (la >= 0 && c == la + 1)
                    check({tag, "_pending_set"}, {15'h0, pending}, 16'h1);
                load = 1'b0;
                if (c == la) begin value_in = va; load = 1'b1; end
                if (c == lb) begin value_in = vb; load = 1'b1; end
                tick();
                c++;
            end
        end
        load = 1'b0;
        check({tag, "_fd_pulse"}, {15'h0, frame_done}, 16'h1);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        value_in = 16'h0;
        load     = 1'b0;
        lz_en    = 1'b0;

        // Reset and idle with enable low
        repeat (3) tick();
        check_blank("rst");
        check("rst_fd", {15'h0, frame_done}, 16'h0);
        check("rst_pending", {15'h0, pending}, 16'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_blank("idle");
            check("idle_fd", {15'h0, frame_done}, 16'h0);
        end
        check("idle_pending", {15'h0, pending}, 16'h0);

        // Basic scan of 1234
        value_in = 16'h1234;
        load     = 1'b1;
        tick();
        load = 1'b0;
        check("load_pending", {15'h0, pending}, 16'h1);
        enable = 1'b1;
        tick();
        check("commit_pending", {15'h0, pending}, 16'h0);
        check("first_fd", {15'h0, frame_done}, 16'h0);
        run_frame("f1234a", 16'h1234, -1, 16'h0, -1, 16'h0);
        run_frame("f1234b", 16'h1234, -1, 16'h0, -1, 16'h0);

        // Leading-zero suppression
        lz_en = 1'b1;
        run_frame("lz_pre", 16'h1234, 0, 16'h0070, -1, 16'h0);
        check("lz_pre_pending", {15'h0, pending}, 16'h0);
        run_frame("lz0070", 16'hFF70, 0, 16'h0000, -1, 16'h0);
        run_frame("lz0000", 16'hFFF0, -1, 16'h0, -1, 16'h0);
        lz_en = 1'b0;
        run_frame("nolz0000", 16'h0000, 0, 16'h1234, -1, 16'h0);

        // Double buffering, no tearing, load on commit edge
        run_frame("buf1234", 16'h1234, 12, 16'h5678, -1, 16'h0);
        check("buf_commit_pending", {15'h0, pending}, 16'h0);
        run_frame("buf5678", 16'h5678, 5, 16'h2468, 19, 16'h1357);
        check("edge_load_pending", {15'h0, pending}, 16'h1);
        run_frame("buf2468", 16'h2468, -1, 16'h0, -1, 16'h0);
        check("after_edge_pending", {15'h0, pending}, 16'h0);
        run_frame("buf1357", 16'h1357, -1, 16'h0, -1, 16'h0);

        // Enable dropped during digit 2
        repeat (12) tick();
        check("dis_pre_an", {12'h0, an_n}, 16'h000B);
        check("dis_pre_bcd", {12'h0, bcd_out}, 16'h0003);
        enable = 1'b0;
        tick();
        check_blank("dis");
        check("dis_fd", {15'h0, frame_done}, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_blank("dis_hold");
        end
        enable = 1'b1;
        tick();
        run_frame("reen", 16'h1357, -1, 16'h0, -1, 16'h0);

        // Asynchronous reset mid-SHOW
        value_in = 16'h9876;
        load     = 1'b1;
        tick();
        load = 1'b0;
        check("arst_pre_pending", {15'h0, pending}, 16'h1);
        check("arst_pre_an", {12'h0, an_n}, 16'h000E);
        check("arst_pre_bcd", {12'h0, bcd_out}, 16'h0007);
        #2;
        rst_n = 1'b0;
        #1;
        check_blank("arst");
        check("arst_fd", {15'h0, frame_done}, 16'h0);
        check("arst_pending", {15'h0, pending}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_pending", {15'h0, pending}, 16'h0);
        run_frame("post_rst", 16'h0000, -1, 16'h0, -1, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one BCD-to-7-segment decoder between NUM_DIGITS digits of a common-anode display. It holds a double-buffered BCD value and drives one 4-bit code to the shared decoder, which produces active-low segments and blanks for codes above 9. It also drives the active-low digit enables, with dead-time between digits and optional leading-zero suppression. It sits between the ALU result path and the decoder/display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (≥2); digit 0 = least significant
SCAN_DIV, 50000, clock cycles each digit is lit (≥1)
BLANK_CYCLES, 500, dead-time cycles with all anodes off before each digit (≥0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  scan run; low forces idle/blank
value_in  in  4*NUM_DIGITS  packed BCD, nibble i = digit i
load  in  1  one-cycle strobe: capture value_in into shadow
lz_en  in  1  leading-zero suppression enable
bcd_out  out  4  code to shared decoder {W,X,Y,Z}; 4'hF = blank
an_n  out  NUM_DIGITS  active-low digit enables, at most one low
frame_done  out  1  one-cycle pulse at end of each full frame
pending  out  1  shadow holds a value not yet displayed

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, idx 0, counter 0, shadow 0, disp 0, pending 0, bcd_out 4'hF, an_n all 1, frame_done 0. All outputs are registered. Reset applies immediately, mid-frame included.
- States:
  - IDLE: an_n all 1, bcd_out F.
  - BLANK: an_n all 1, bcd_out F.
  - SHOW: an_n[idx]=0, bcd_out = code of digit idx.
- Transitions:
  - IDLE→BLANK on enable=1, with idx=0 and commit; if BLANK_CYCLES=0, go directly to SHOW.
  - BLANK→SHOW after exactly BLANK_CYCLES cycles.
  - SHOW→BLANK (or SHOW if BLANK_CYCLES=0) after exactly SCAN_DIV cycles, with idx+1.
  - When idx=NUM_DIGITS-1 ends, idx wraps to 0, frame_done pulses for one cycle, and commit occurs on that same edge.
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+SCAN_DIV) cycles.
- Commit: if pending=1, disp<=shadow and pending<=0; otherwise disp is unchanged. The displayed value never changes mid-frame (no tearing).
- load:
  - shadow<=value_in, pending<=1.
  - Back-to-back loads: last wins.
  - load on a commit edge: disp takes the old shadow, shadow takes value_in, pending stays 1.
  - load is accepted in every state, including IDLE.
- enable deasserted in any non-IDLE state: next edge goes to IDLE, idx=0, counter=0, no frame_done. shadow, disp and pending are preserved.
- Leading-zero suppression, evaluated on disp:
  - For i≥1, digit i is blanked (bcd_out=F) when lz_en=1 and nibbles NUM_DIGITS-1..i are all 0.
  - Digit 0 is never suppressed.
  - lz_en is sampled combinationally each cycle.
- Invalid nibbles (A–F) pass through unchanged; the decoder blanks them.
- Counter width = clog2(max(SCAN_DIV,BLANK_CYCLES)+1). Counter is cleared on each state entry.

Decomposition:
- Package display_scan_pkg:
  - state enum {IDLE, BLANK, SHOW}
  - BLANK_CODE = 4'hF
  - function for the counter width
- One natural combinational sub-module, lz_mask: it takes disp and lz_en and returns a NUM_DIGITS-bit suppress mask.
- The decoder itself is instantiated at board top, not inside this block.

Test Plan:
Common configuration: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.
1. Reset held, then released with enable=0 -> an_n=4'b1111, bcd_out=4'hF, frame_done=0, pending=0; stays there for 20 cycles.
2. load value_in=16'h1234, then enable=1 -> pattern 1 blank + 4 cycles each: bcd 4/an_n 1110, 3/1101, 2/1011, 1/0111. frame_done pulses every 20 cycles; pending falls at the first commit.
3. lz_en=1 with 16'h0070 -> digits 3,2 bcd F; digit 1 = 7; digit 0 = 0. With 16'h0000 only digit 0 shows 0. With lz_en=0 all digits show 0.
4. Frame showing 1234; load 16'h5678 mid-digit-2 -> pending=1, rest of frame still 1234. Next frame shows 8,7,6,5; pending=0 after the frame_done edge. Second load on the exact commit edge leaves pending=1.
5. enable dropped during SHOW of digit 2 -> next cycle an_n=1111, bcd F, no frame_done. Re-enable restarts at digit 0 after 1 blank cycle.
6. rst_n asserted mid-SHOW between clock edges -> outputs go to reset values immediately (no clock edge). disp/shadow/pending clear, so the next frame shows 0000.
